// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and FSM encoding for the data-memory arbiter
package dmem_pkg;

    localparam int MEM_DEPTH  = 4096;
    localparam int DEF_ADDR_W = $clog2(MEM_DEPTH);
    localparam int DEF_DATA_W = 12;
    localparam int DEF_BUS_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, search starts at ptr and wraps
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            winner = N'(1) << idx;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data memory between cores
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUS_W     = DEF_BUS_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_ready,
    input  logic [NUM_CORES-1:0]           req,
    input  logic [NUM_CORES-1:0]           we,
    input  logic [NUM_CORES*ADDR_W-1:0]    addr,
    input  logic [NUM_CORES*BUS_W-1:0]     wdata,
    output logic [NUM_CORES-1:0]           gnt,
    output logic [NUM_CORES-1:0]           rvalid,
    output logic [DATA_W-1:0]              rdata,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_t             state, state_n;
    logic [IDX_W-1:0]       ptr, ptr_n;
    logic [IDX_W-1:0]       cur_idx, cur_idx_n;
    logic                   cur_we, cur_we_n;
    logic [NUM_CORES-1:0]   gnt_n, rvalid_n;
    logic [DATA_W-1:0]      rdata_n, mem_wdata_n;
    logic [ADDR_W-1:0]      mem_addr_n;
    logic                   mem_we_n;

    logic [NUM_CORES-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    logic [ADDR_W-1:0]      addr_a  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_a [NUM_CORES];
    logic [NUM_CORES-1:0]   wdata_hi_par;
    logic                   unused_wdata_hi;

    // Only the low DATA_W bits of each bus word reach the memory.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_a[i]       = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i]      = wdata[i*BUS_W +: DATA_W];
        assign wdata_hi_par[i] = ^wdata[i*BUS_W+DATA_W +: BUS_W-DATA_W];
    end
    assign unused_wdata_hi = ^wdata_hi_par;

    rr_pick #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cur_idx_n   = cur_idx;
        cur_we_n    = cur_we;
        gnt_n       = '0;
        rvalid_n    = '0;
        rdata_n     = rdata;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        case (state)
            ST_IDLE: begin
                if (mem_ready && pick_valid) begin
                    state_n     = ST_ISSUE;
                    gnt_n       = pick_onehot;
                    mem_we_n    = we[pick_idx];
                    mem_addr_n  = addr_a[pick_idx];
                    mem_wdata_n = wdata_a[pick_idx];
                    cur_idx_n   = pick_idx;
                    cur_we_n    = we[pick_idx];
                    ptr_n       = (pick_idx == IDX_W'(NUM_CORES-1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_n = cur_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Memory output is registered, so read data is valid one cycle after ISSUE.
                rdata_n  = mem_rdata;
                rvalid_n = NUM_CORES'(1) << cur_idx;
                state_n  = ST_RESP;
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cur_idx   <= '0;
            cur_we    <= 1'b0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cur_idx   <= cur_idx_n;
            cur_we    <= cur_we_n;
            gnt       <= gnt_n;
            rvalid    <= rvalid_n;
            rdata     <= rdata_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

    localparam int NC   = 4;
    localparam int AW   = 12;
    localparam int DW   = 12;
    localparam int BW   = 17;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_ready;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we;
    logic [NC*AW-1:0]  addr;
    logic [NC*BW-1:0]  wdata;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    dmem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BUS_W     (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_ready (mem_ready),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 'h044) return 12'h123;
        return DW'((i * 37 + 5) & 'hfff);
    endfunction

    // Device memory: registered read, written when mem_we is high.
    logic [DW-1:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        mem_rdata <= '0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: per-cycle expected outputs scheduled by transaction.
    logic [DW-1:0]  ref_mem [0:4095];
    logic [NC-1:0]  exp_gnt  [0:MAXC-1];
    logic [NC-1:0]  exp_rv   [0:MAXC-1];
    logic           exp_mwe  [0:MAXC-1];
    logic [AW-1:0]  exp_addr [0:MAXC-1];
    logic [DW-1:0]  exp_wd   [0:MAXC-1];
    logic [DW-1:0]  exp_rd   [0:MAXC-1];
    logic [AW-1:0]  hold_addr;
    logic [DW-1:0]  hold_wd;
    logic [DW-1:0]  hold_rd;
    int cyc, free_at, rr_ptr;
    int n_pass, n_checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int onehot_idx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic decide();
        int k;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!rst_n || !mem_ready || req == '0 || cyc < free_at) return;
        k = -1;
        for (int i = 0; i < NC; i++) begin
            int c;
            c = (rr_ptr + i) % NC;
            if (k < 0 && req[c]) k = c;
        end
        a = addr[k*AW +: AW];
        d = wdata[k*BW +: DW];
        exp_gnt[cyc+1]  = NC'(1 << k);
        exp_mwe[cyc+1]  = we[k];
        exp_addr[cyc+1] = a;
        exp_wd[cyc+1]   = d;
        if (we[k]) begin
            ref_mem[a] = d;
            free_at    = cyc + 2;
        end else begin
            exp_rv[cyc+3] = NC'(1 << k);
            exp_rd[cyc+3] = ref_mem[a];
            free_at       = cyc + 4;
        end
        rr_ptr = (k + 1) % NC;
    endtask

    task automatic tick();
        decide();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_gnt[cyc] != '0) begin
            hold_addr = exp_addr[cyc];
            hold_wd   = exp_wd[cyc];
        end
        if (exp_rv[cyc] != '0) hold_rd = exp_rd[cyc];
        check("gnt", gnt, exp_gnt[cyc]);
        check("rvalid", rvalid, exp_rv[cyc]);
        check("mem_we", mem_we, exp_mwe[cyc]);
        check("mem_addr", mem_addr, hold_addr);
        check("mem_wdata", mem_wdata, hold_wd);
        check("rdata", rdata, hold_rd);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        for (int i = cyc; i <= cyc + 5; i++) begin
            exp_gnt[i] = '0;
            exp_rv[i]  = '0;
            exp_mwe[i] = 1'b0;
        end
        hold_addr = '0;
        hold_wd   = '0;
        hold_rd   = '0;
        rr_ptr    = 0;
        free_at   = 0;
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    task automatic new_req(input int k);
        req[k]             = 1'b1;
        we[k]              = 1'($urandom % 2);
        addr[k*AW +: AW]   = ($urandom % 8 == 0) ? 12'h044 : AW'($urandom % 16);
        wdata[k*BW +: BW]  = BW'($urandom);
    endtask

    int exp_order [9] = '{0, 1, 2, 3, 0, 1, 2, 0, 2};
    int n_g, last_g, got3;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < MAXC; i++) begin
            exp_gnt[i] = '0; exp_rv[i] = '0; exp_mwe[i] = 1'b0;
            exp_addr[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0;
        end
        n_pass = 0; n_checks = 0; cyc = 0;
        rst_n = 1'b1; mem_ready = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        #1;

        // Reset with mem_ready low; no grant until it rises.
        req = 4'b0001;
        apply_reset(3);
        repeat (10) tick();
        mem_ready = 1'b1;
        tick();
        check("ready_gnt", gnt, 4'b0001);
        req = '0;
        repeat (3) tick();

        // Core 2 write: upper bus bits discarded.
        req = 4'b0100; we = 4'b0100;
        addr[2*AW +: AW] = 12'h004;
        wdata[2*BW +: BW] = 17'h1_0ABC;
        tick();
        check("wr_gnt", gnt, 4'b0100);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 12'h004);
        check("wr_data", mem_wdata, 12'hABC);
        req = '0; we = '0;
        tick();
        check("wr_we_off", mem_we, 0);
        tick();

        // Core 1 read of a preloaded word.
        req = 4'b0010; we = '0;
        addr[1*AW +: AW] = 12'h044;
        tick();
        req = '0;
        tick();
        check("rd_early", rvalid, 0);
        tick();
        check("rd_rvalid", rvalid, 4'b0010);
        check("rd_data", rdata, 12'h123);
        tick();
        check("rd_pulse", rvalid, 0);

        // Round-robin order with all cores writing, then a narrowed request set.
        apply_reset(2);
        req = 4'b1111; we = 4'b1111;
        for (int k = 0; k < NC; k++) begin
            addr[k*AW +: AW]  = AW'($urandom % 16);
            wdata[k*BW +: BW] = BW'($urandom);
        end
        n_g = 0; last_g = 0;
        for (int i = 0; i < 40 && n_g < 9; i++) begin
            tick();
            if (gnt != '0) begin
                check("rr_order", onehot_idx(gnt), exp_order[n_g]);
                if (n_g > 0) check("rr_gap", cyc - last_g, 2);
                last_g = cyc;
                n_g++;
                if (n_g == 7) req = 4'b0101;
                if (n_g == 9) req = '0;
            end
        end
        check("rr_count", n_g, 9);
        we = '0;
        repeat (2) tick();

        // Reset during the WAIT of a core 3 read.
        req = 4'b1000; we = '0;
        addr[3*AW +: AW] = 12'h00A;
        tick();
        check("rst_rd_gnt", gnt, 4'b1000);
        req = '0;
        tick();
        apply_reset(2);
        repeat (3) tick();
        req = 4'b1001; we = 4'b1001;
        tick();
        check("rst_ptr", gnt, 4'b0001);
        req = 4'b1000;
        got3 = 0;
        for (int i = 0; i < 10 && got3 == 0; i++) begin
            tick();
            if (gnt[3]) got3 = 1;
        end
        check("rst_core3", got3, 1);
        req = '0; we = '0;
        repeat (2) tick();

        // mem_ready drops during ISSUE of a read.
        req = 4'b0001; we = '0;
        addr[0*AW +: AW] = 12'h044;
        tick();
        mem_ready = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        check("mr_rvalid", rvalid, 4'b0001);
        repeat (5) begin
            tick();
            check("mr_nognt", gnt, 0);
        end
        mem_ready = 1'b1;
        tick();
        check("mr_resume", gnt, 4'b0010);
        req = '0;
        repeat (3) tick();

        // Randomized traffic obeying the core handshake.
        repeat (1500) begin
            tick();
            for (int k = 0; k < NC; k++) begin
                if (gnt[k]) begin
                    if ($urandom % 2 == 1) new_req(k);
                    else req[k] = 1'b0;
                end else if (!req[k] && $urandom % 3 == 0) begin
                    new_req(k);
                end
            end
            mem_ready = ($urandom % 10) != 0;
        end
        req = '0;
        mem_ready = 1'b1;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
